// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and depth for the pipeline skid buffer
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_t;
   localparam logic [1:0] SKID_DEPTH = 2'd2;
endpackage

// File: rtl/pipe_skid_buffer_if.sv
// pipe_skid_buffer_if: valid/ready handshake bundle for both sides of the skid buffer
interface pipe_skid_buffer_if #(parameter int p_nbits = 32);
   logic               in_val;
   logic               in_rdy;
   logic [p_nbits-1:0] in_msg;
   logic               out_val;
   logic               out_rdy;
   logic [p_nbits-1:0] out_msg;
   logic [1:0]         count;
   modport slave (input in_val, in_msg, out_rdy, output in_rdy, out_val, out_msg, count);
   modport master (output in_val, in_msg, out_rdy, input in_rdy, out_val, out_msg, count);
endinterface

// File: rtl/pipe_skid_buffer_reg.sv
// Register_RTL: enable register with synchronous clear
module Register_RTL #(parameter int p_nbits = 32) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [p_nbits-1:0] d,
   output logic [p_nbits-1:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic register with registered valid/ready on both sides
module pipe_skid_buffer
   import pipe_pkg::*;
#(parameter int p_nbits = 32) (
   input logic clk,
   input logic rst,
   pipe_skid_buffer_if.slave bus
);
   skid_state_t        state, state_n;
   logic               in_fire, out_fire, main_en, skid_en;
   logic [p_nbits-1:0] main_d, main_q, skid_q;
   assign bus.out_val = state != EMPTY;
   assign bus.in_rdy  = state != FULL;
   assign bus.out_msg = main_q;
   assign bus.count   = state == FULL ? SKID_DEPTH : state == ONE ? 2'd1 : 2'd0;
   assign in_fire  = bus.in_val && bus.in_rdy;
   assign out_fire = bus.out_val && bus.out_rdy;
   always_comb begin
      state_n = state == EMPTY ? (in_fire ? ONE : EMPTY)
              : state == ONE   ? (in_fire && !out_fire ? FULL : !in_fire && out_fire ? EMPTY : ONE)
              : state == FULL  ? (out_fire ? ONE : FULL)
              : EMPTY;
      main_en = (state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire)
              || (state == FULL && out_fire);
      skid_en = state == ONE && in_fire && !out_fire;
      main_d  = state == FULL ? skid_q : bus.in_msg;
   end
   always_ff @(posedge clk)
      if (rst) state <= EMPTY;
      else state <= state_n;
   Register_RTL #(.p_nbits(p_nbits)) u_main (
      .clk(clk), .rst(rst), .en(main_en), .d(main_d), .q(main_q)
   );
   // skid only ever captures the younger message while main still holds the head
   Register_RTL #(.p_nbits(p_nbits)) u_skid (
      .clk(clk), .rst(rst), .en(skid_en), .d(bus.in_msg), .q(skid_q)
   );
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed vector table plus randomized queue-model check
module tb_pipe_skid_buffer;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
   pipe_skid_buffer_if #(.p_nbits(32)) bus ();
   pipe_skid_buffer #(.p_nbits(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      logic        rst;
      logic        in_val;
      logic [31:0] in_msg;
      logic        out_rdy;
      logic        e_rdy;
      logic        e_val;
      logic [31:0] e_msg;
      logic [1:0]  e_cnt;
   } vec_t;
   vec_t vt[$];
   logic [31:0] q[$];
   logic [31:0] last;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic add(input logic r, input logic iv, input logic [31:0] m, input logic ordy,
                      input logic er, input logic ev, input logic [31:0] em, input logic [1:0] ec);
      vec_t v;
      v.rst = r; v.in_val = iv; v.in_msg = m; v.out_rdy = ordy;
      v.e_rdy = er; v.e_val = ev; v.e_msg = em; v.e_cnt = ec;
      vt.push_back(v);
   endtask
   initial begin
      rst = 1'b1; bus.in_val = 1'b0; bus.in_msg = '0; bus.out_rdy = 1'b0;
      add(1, 1, 32'h99, 0, 1, 0, 32'h0, 0);
      add(1, 1, 32'h98, 0, 1, 0, 32'h0, 0);
      add(0, 0, 32'h77, 0, 1, 0, 32'h0, 0);
      add(0, 1, 32'h11, 1, 1, 1, 32'h11, 1);
      add(0, 1, 32'h22, 1, 1, 1, 32'h22, 1);
      add(0, 1, 32'h33, 1, 1, 1, 32'h33, 1);
      add(0, 1, 32'h44, 1, 1, 1, 32'h44, 1);
      add(0, 0, 32'h0, 1, 1, 0, 32'h44, 0);
      add(0, 1, 32'hA, 0, 1, 1, 32'hA, 1);
      add(0, 1, 32'hB, 0, 0, 1, 32'hA, 2);
      add(0, 1, 32'hC, 0, 0, 1, 32'hA, 2);
      add(0, 1, 32'hC, 1, 1, 1, 32'hB, 1);
      add(0, 1, 32'hC, 1, 1, 1, 32'hC, 1);
      add(0, 0, 32'h0, 1, 1, 0, 32'hC, 0);
      add(0, 1, 32'h5, 0, 1, 1, 32'h5, 1);
      add(0, 1, 32'h6, 1, 1, 1, 32'h6, 1);
      add(0, 0, 32'h0, 1, 1, 0, 32'h6, 0);
      add(0, 1, 32'h1, 0, 1, 1, 32'h1, 1);
      add(0, 1, 32'h2, 0, 0, 1, 32'h1, 2);
      add(1, 1, 32'h3, 1, 1, 0, 32'h0, 0);
      add(0, 0, 32'h0, 1, 1, 0, 32'h0, 0);
      add(0, 0, 32'h0, 0, 1, 0, 32'h0, 0);
      for (int i = 0; i < vt.size(); i++) begin
         rst = vt[i].rst; bus.in_val = vt[i].in_val; bus.in_msg = vt[i].in_msg;
         bus.out_rdy = vt[i].out_rdy;
         @(posedge clk); #1;
         chk($sformatf("vec%0d in_rdy", i), 32'(bus.in_rdy), 32'(vt[i].e_rdy));
         chk($sformatf("vec%0d out_val", i), 32'(bus.out_val), 32'(vt[i].e_val));
         chk($sformatf("vec%0d out_msg", i), bus.out_msg, vt[i].e_msg);
         chk($sformatf("vec%0d count", i), 32'(bus.count), 32'(vt[i].e_cnt));
      end
      q.delete(); last = '0;
      for (int c = 0; c < 10000; c++) begin
         logic in_f, out_f;
         rst = ($urandom_range(0, 499) == 0);
         bus.in_val = $urandom_range(0, 99) < 60;
         bus.out_rdy = $urandom_range(0, 99) < 55;
         bus.in_msg = $urandom;
         in_f = bus.in_val && q.size() < 2;
         out_f = bus.out_rdy && q.size() > 0;
         @(posedge clk); #1;
         if (rst) begin
            q.delete(); last = '0;
         end else begin
            if (out_f) last = q.pop_front();
            if (in_f) q.push_back(bus.in_msg);
         end
         chk("rnd in_rdy", 32'(bus.in_rdy), 32'(q.size() < 2));
         chk("rnd out_val", 32'(bus.out_val), 32'(q.size() > 0));
         chk("rnd count", 32'(bus.count), q.size());
         chk("rnd out_msg", bus.out_msg, q.size() > 0 ? q[0] : last);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pipe_skid_buffer.md
# pipe_skid_buffer

Two-entry elastic pipeline register with valid/ready handshakes on both sides. It sits between TinyRV1 pipeline stages, such as F→D and X→M, or in front of the memory request port. It decouples stage stalls while keeping full throughput. Every output, including `in_rdy`, comes from a flop, so no combinational path runs from `out_rdy` to `in_rdy`.

## Interface
Parameters:
- `p_nbits`, default 32: message width in bits.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_val`  in  1: upstream message valid.
- `in_rdy`  out  1: buffer can accept a message this cycle.
- `in_msg`  in  `p_nbits`: upstream message.
- `out_val`  out  1: buffer holds a message for downstream.
- `out_rdy`  in  1: downstream accepts `out_msg` this cycle.
- `out_msg`  out  `p_nbits`: head message.
- `count`  out  2: occupancy, 0..2 (debug/perf).

## Operation
- In-fire = `in_val && in_rdy`. Out-fire = `out_val && out_rdy`. Transfers commit on the rising edge of `clk`.
- Storage:
  - `main`: the head entry, which drives `out_msg`.
  - `skid`: the overflow entry.
- States:
  - EMPTY (`count`=0)
  - ONE (`count`=1; `main` valid)
  - FULL (`count`=2; both valid, `skid` younger)
- Combinational outputs of state only:
  - `out_val` = (state != EMPTY)
  - `in_rdy` = (state != FULL)
  - `out_msg` = `main`
- Transitions:
  - EMPTY, in-fire → ONE; `main` ← `in_msg`.
  - EMPTY, no in-fire → EMPTY. Out-fire is impossible here.
  - ONE, in-fire and out-fire → ONE; `main` ← `in_msg`.
  - ONE, in-fire only → FULL; `skid` ← `in_msg`.
  - ONE, out-fire only → EMPTY. `main` keeps its stale value.
  - ONE, neither → ONE.
  - FULL, out-fire → ONE; `main` ← `skid`. `in_val` is ignored because `in_rdy`=0.
  - FULL, no out-fire → FULL.
- Ordering: strict FIFO. No message is dropped or duplicated.
- `in_msg` is sampled only on in-fire. `out_val` and `out_msg` stay stable until out-fire.
- Unreachable state encoding → EMPTY on the next edge.
- Reset (synchronous, has priority over all fire events):
  - state ← EMPTY; `main`, `skid` ← 0.
  - After the reset edge: `out_val`=0, `in_rdy`=1, `out_msg`=0, `count`=0.
  - Reset mid-operation discards both entries. Fires presented in the reset cycle do not commit.

## Timing
- Latency: a message accepted at edge N is visible on `out_msg`, with `out_val`=1, in the cycle after edge N.
- Throughput: one message per cycle in steady state (ONE with both sides firing).
- Stall absorption: with `out_rdy` low, the buffer accepts exactly 2 messages. `in_rdy` falls in the cycle after the second accept.
- Release: `in_rdy` rises in the cycle after the first out-fire from FULL.
- Worst-case bubble: none. A drain from FULL followed by a refill sustains 1 message per cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - `typedef enum logic [1:0] skid_state_t {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}`.
  - Constant `SKID_DEPTH = 2`.
- `main` and `skid` are instances of the codebase enable register `Register_RTL` (`p_nbits`). Their enables and the `main` input mux (`in_msg` vs `skid`) come from the state logic.
- The state register is a plain `always_ff` with synchronous reset.

## Test plan
- Reset then idle: assert `rst` 2 cycles with `in_val`=1 → after release `out_val`=0, `in_rdy`=1, `count`=0, `out_msg`=0; nothing is captured.
- Streaming: send 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_rdy`=1 → outputs appear the same order, each 1 cycle after its accept, `count`=1 throughout.
- Backpressure: `out_rdy`=0, send 0xA, 0xB, 0xC → 0xA and 0xB accepted, `in_rdy`=0 with 0xC held, `count`=2. Raise `out_rdy` → 0xA, 0xB, 0xC are delivered in order with no gaps.
- Simultaneous fire in ONE: hold 0x5, present 0x6 with `out_rdy`=1 → 0x5 leaves, `main`=0x6 next cycle, `count` stays 1.
- Reset while FULL: fill with 0x1, 0x2, assert `rst` together with `out_rdy`=1 → after the edge `count`=0, `out_val`=0; neither message appears afterwards.
- Random: random `in_val`/`out_rdy` for 10k cycles against a scoreboard → order preserved, no loss, `out_msg` stable while `out_val && !out_rdy`.
